// File: rtl/video_pll_pkg.sv
// Shared types and default timing for the video PLL reset sequencer.
// Optional feature macro used by the top: LOCK_LOSS_COUNT_EN.
package video_pll_pkg;

    typedef enum logic [2:0] {
        PLL_RESET,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } pll_seq_state_t;

    // Defaults assume the 50 MHz reference clock.
    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 50000;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRIES   = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-high reset to 0.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/video_pll_reset_ctrl.sv
// Video PLL reset/lock sequencer on the free-running reference clock.
// Define LOCK_LOSS_COUNT_EN to add the saturating lock_loss_cnt output.
module video_pll_reset_ctrl
    import video_pll_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
    input  logic                               refclk,
    input  logic                               rst,
    input  logic                               pll_locked,
    output logic                               pll_rst,
    output logic                               video_rst,
    output logic                               pll_ready,
    output logic                               pll_fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
    output pll_seq_state_t                     state_dbg
`ifdef LOCK_LOSS_COUNT_EN
    ,
    output logic [7:0]                         lock_loss_cnt
`endif
);

    localparam int RW      = $clog2(MAX_RETRIES + 1);
    localparam int CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

    pll_seq_state_t  state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [RW-1:0]   retry_nxt;
    logic            lk_s;
`ifdef LOCK_LOSS_COUNT_EN
    logic            run_exit;
`endif

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lk_s)
    );

    assign state_dbg = state;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        retry_nxt = retry_cnt;
`ifdef LOCK_LOSS_COUNT_EN
        run_exit  = 1'b0;
`endif
        case (state)
            PLL_RESET: begin
                if (cnt == RST_LAST) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end
            end
            WAIT_LOCK: begin
                // Lock takes priority over a timeout landing on the same cycle.
                if (lk_s) begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    retry_nxt = retry_cnt + RW'(1);
                    cnt_nxt   = '0;
                    state_nxt = (retry_nxt == RETRY_LIMIT) ? FAIL : PLL_RESET;
                end
            end
            STABLE: begin
                if (!lk_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                    retry_nxt = '0;
                end
            end
            RUN: begin
                cnt_nxt = '0;
                if (!lk_s) begin
                    state_nxt = PLL_RESET;
`ifdef LOCK_LOSS_COUNT_EN
                    run_exit  = 1'b1;
`endif
                end
            end
            FAIL: begin
                cnt_nxt = '0;
            end
            default: begin
                state_nxt = PLL_RESET;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the entry edge.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state     <= PLL_RESET;
            cnt       <= '0;
            retry_cnt <= '0;
            pll_rst   <= 1'b1;
            video_rst <= 1'b1;
            pll_ready <= 1'b0;
            pll_fail  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            retry_cnt <= retry_nxt;
            pll_rst   <= (state_nxt == PLL_RESET) || (state_nxt == FAIL);
            video_rst <= (state_nxt != RUN);
            pll_ready <= (state_nxt == RUN);
            pll_fail  <= (state_nxt == FAIL);
        end
    end

`ifdef LOCK_LOSS_COUNT_EN
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lock_loss_cnt <= '0;
        end else if (run_exit && (lock_loss_cnt != 8'hFF)) begin
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
        end
    end
`endif

endmodule
